// File: rtl/deserializer.sv
// ---------------------------------------------------------------------------
// deserializer
//
// Receive side of the serial link. Serial bits arrive MSB-first, one per
// clock, qualified by ser_data_val_i. A run of contiguous valid cycles forms
// one word. The word is closed either when the valid strobe drops or when
// DATA_W bits have been collected, and is then presented on data_o with its
// bit count on data_mod_o and a one-cycle data_val_o strobe.
//
// Ports:
//   clk_i          clock, all logic on the rising edge
//   rst_i          synchronous active-high reset
//   ser_data_i     serial data bit, MSB of the word first
//   ser_data_val_i ser_data_i valid this cycle
//   data_o         reassembled word, first bit at data_o[DATA_W-1],
//                  unreceived low bits zero
//   data_mod_o     number of valid bits in data_o (1..DATA_W)
//   data_val_o     one-cycle strobe, data_o/data_mod_o valid
//   busy_o         high while a word is partially received
// ---------------------------------------------------------------------------
module deserializer #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ser_data_i,
    input  logic              ser_data_val_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  data_mod_o,
    output logic              data_val_o,
    output logic              busy_o
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_W);

    state_t            state;
    logic [DATA_W-1:0] shift;
    logic [CNT_W-1:0]  count;

    logic [DATA_W-1:0] merged;
    logic [CNT_W-1:0]  count_next;
    logic [CNT_W-1:0]  pos;

    // The shift register and count are cleared whenever a word closes, so
    // in IDLE count is zero and the first bit lands at DATA_W-1 through the
    // same insertion path used for every later bit.
    always_comb begin
        pos        = FULL - CNT_W'(1) - count;
        merged     = shift | (DATA_W'(ser_data_i) << pos);
        count_next = count + CNT_W'(1);
    end

    // A word closes on the edge that samples its DATA_W-th bit, or on the
    // first invalid edge after a partial word. Closing always returns to
    // IDLE, so a valid bit on the very next edge starts a fresh word with
    // no bit lost, while busy_o still drops for one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            shift      <= '0;
            count      <= '0;
            data_o     <= '0;
            data_mod_o <= '0;
            data_val_o <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            data_val_o <= 1'b0;
            if (ser_data_val_i) begin
                if (count_next == FULL) begin
                    data_o     <= merged;
                    data_mod_o <= FULL;
                    data_val_o <= 1'b1;
                    shift      <= '0;
                    count      <= '0;
                    state      <= IDLE;
                    busy_o     <= 1'b0;
                end else begin
                    shift      <= merged;
                    count      <= count_next;
                    state      <= SHIFT;
                    busy_o     <= 1'b1;
                end
            end else if (state == SHIFT) begin
                data_o     <= shift;
                data_mod_o <= count;
                data_val_o <= 1'b1;
                shift      <= '0;
                count      <= '0;
                state      <= IDLE;
                busy_o     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// ---------------------------------------------------------------------------
// tb_deserializer
//
// Self-checking bench for deserializer. A stream-level reference model
// collects valid bits into a queue and closes a word when the strobe drops
// or sixteen bits are held; every cycle the DUT outputs are compared with
// the model. Directed scenarios additionally compare captured words with
// hand-derived constants, and a random loopback phase compares received
// words with the transmitted words masked to their length.
// ---------------------------------------------------------------------------
module tb_deserializer;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 5;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              ser_data_i = 1'b0;
    logic              ser_data_val_i = 1'b0;
    logic [DATA_W-1:0] data_o;
    logic [CNT_W-1:0]  data_mod_o;
    logic              data_val_o;
    logic              busy_o;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit                model_bits[$];
    logic [DATA_W-1:0] exp_data = '0;
    logic [CNT_W-1:0]  exp_mod  = '0;
    logic              exp_val  = 1'b0;
    logic              exp_busy = 1'b0;

    // Words seen on the DUT output, packed as {mod, data}
    logic [CNT_W+DATA_W-1:0] got[$];
    // Words sent in the loopback phase, packed as {len, masked data}
    logic [CNT_W+DATA_W-1:0] sent[$];

    deserializer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .ser_data_i    (ser_data_i),
        .ser_data_val_i(ser_data_val_i),
        .data_o        (data_o),
        .data_mod_o    (data_mod_o),
        .data_val_o    (data_val_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Compare one observed value against its expected value.
    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Close the word currently held by the model.
    task automatic model_emit();
        logic [DATA_W-1:0] w;
        w = '0;
        for (int i = 0; i < model_bits.size(); i++)
            w[DATA_W-1-i] = model_bits[i];
        exp_data = w;
        exp_mod  = CNT_W'(model_bits.size());
        exp_val  = 1'b1;
        model_bits.delete();
    endtask

    // Advance the model by one rising edge with the given inputs.
    task automatic model_edge(input bit rst, input bit v, input bit d);
        exp_val = 1'b0;
        if (rst) begin
            model_bits.delete();
            exp_data = '0;
            exp_mod  = '0;
        end else if (v) begin
            model_bits.push_back(d);
            if (model_bits.size() == DATA_W) model_emit();
        end else if (model_bits.size() > 0) begin
            model_emit();
        end
        exp_busy = (model_bits.size() > 0);
    endtask

    // Drive one clock of stimulus, then check the DUT against the model.
    task automatic apply_stimulus(input bit rst, input bit v, input bit d);
        rst_i          = rst;
        ser_data_val_i = v;
        ser_data_i     = d;
        @(posedge clk_i);
        model_edge(rst, v, d);
        #1;
        check_output("data_val", 32'(data_val_o), 32'(exp_val));
        check_output("busy", 32'(busy_o), 32'(exp_busy));
        check_output("data", 32'(data_o), 32'(exp_data));
        check_output("mod", 32'(data_mod_o), 32'(exp_mod));
        if (data_val_o === 1'b1) got.push_back({data_mod_o, data_o});
    endtask

    task automatic send_bits(input logic [DATA_W-1:0] w, input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b1, w[DATA_W-1-i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, $urandom_range(0, 1) == 1);
    endtask

    // Compare the captured word list against one expected word.
    task automatic check_word(input string tag, input int idx,
                              input logic [DATA_W-1:0] w, input int m);
        if (idx < got.size()) begin
            check_output({tag, "_data"}, 32'(got[idx][DATA_W-1:0]), 32'(w));
            check_output({tag, "_mod"}, 32'(got[idx][CNT_W+DATA_W-1:DATA_W]), 32'(m));
        end else begin
            check_output({tag, "_present"}, 32'(got.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        int busy_cycles;
        logic [DATA_W-1:0] w;
        int len;
        int gap;

        $display("[TB] reset");
        apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b1);
        check_output("reset_data", 32'(data_o), 32'h0);
        check_output("reset_busy", 32'(busy_o), 32'h0);

        $display("[TB] four-bit word");
        got.delete();
        busy_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, 1'b1, (i % 2) == 0);
            if (busy_o === 1'b1) busy_cycles++;
        end
        idle(3);
        check_output("t1_busy_cycles", 32'(busy_cycles), 32'd4);
        check_output("t1_pulses", 32'(got.size()), 32'd1);
        check_word("t1", 0, 16'hA000, 4);

        $display("[TB] full word A5C3");
        got.delete();
        w = 16'hA5C3;
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b0, 1'b1, w[15-i]);
            if (i == 15) check_output("t2_pulse_timing", 32'(data_val_o), 32'h1);
        end
        idle(2);
        check_output("t2_pulses", 32'(got.size()), 32'd1);
        check_word("t2", 0, 16'hA5C3, 16);

        $display("[TB] back-to-back FFFF then 011");
        got.delete();
        send_bits(16'hFFFF, 16);
        send_bits(16'h6000, 3);
        idle(2);
        check_output("t3_pulses", 32'(got.size()), 32'd2);
        check_word("t3a", 0, 16'hFFFF, 16);
        check_word("t3b", 1, 16'h6000, 3);

        $display("[TB] single bit");
        got.delete();
        send_bits(16'h8000, 1);
        idle(4);
        check_output("t4_pulses", 32'(got.size()), 32'd1);
        check_word("t4", 0, 16'h8000, 1);
        check_output("t4_hold", 32'(data_o), 32'h8000);

        $display("[TB] reset mid-word");
        got.delete();
        send_bits(16'hB6D0, 7);
        apply_stimulus(1'b1, 1'b1, 1'b1);
        check_output("t5_reset_data", 32'(data_o), 32'h0);
        check_output("t5_reset_mod", 32'(data_mod_o), 32'h0);
        check_output("t5_reset_busy", 32'(busy_o), 32'h0);
        idle(2);
        check_output("t5_no_pulse", 32'(got.size()), 32'd0);
        send_bits(16'hC000, 2);
        idle(2);
        check_word("t5", 0, 16'hC000, 2);

        $display("[TB] random loopback");
        got.delete();
        sent.delete();
        for (int k = 0; k < 200; k++) begin
            len = $urandom_range(1, 16);
            w   = 16'($urandom);
            send_bits(w, len);
            w = w & ~(16'hFFFF >> len);
            sent.push_back({CNT_W'(len), w});
            gap = $urandom_range(0, 2);
            if (len != 16 && gap == 0) gap = 1;
            idle(gap);
        end
        idle(2);
        check_output("loop_count", 32'(got.size()), 32'(sent.size()));
        for (int k = 0; k < sent.size() && k < got.size(); k++)
            check_output("loop_word", 32'(got[k]), 32'(sent[k]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
